// File: rtl/sobol_stream_ctrl.sv
// Sobol-driven unary stream generator: compares a captured operand against an
// external Sobol RNG for 2^INWD enabled cycles. Ones accumulator: SOBOL_STREAM_CTRL_ACC_EN.
module sobol_stream_ctrl #(
    parameter int INWD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [INWD-1:0] src_data,
    input  logic            hold,
    output logic            rng_en,
    input  logic [INWD-1:0] rng_val,
    output logic            out_bit,
    output logic            out_vld,
    output logic            busy,
    output logic            done,
    output logic [INWD:0]   result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [INWD-1:0] WIN_LAST = '1;
    localparam logic [INWD-1:0] WIN_ONE  = {{(INWD-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [INWD-1:0] data_q, data_d;
    logic [INWD-1:0] win_cnt_q, win_cnt_d;
    logic            out_bit_q, out_bit_d;
    logic            out_vld_q, out_vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            step;
    logic            start_ok;
    logic            cmp_bit;
    logic            last_step;

    assign step      = (state_q == RUN) && !hold;
    assign start_ok  = start && (state_q != RUN);
    assign cmp_bit   = data_q > rng_val;
    assign last_step = step && (win_cnt_q == WIN_LAST);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        data_d    = data_q;
        win_cnt_d = win_cnt_q;
        out_bit_d = out_bit_q;
        out_vld_d = 1'b0;

        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase

        if (start_ok) begin
            data_d    = src_data;
            win_cnt_d = '0;
        end

        // Counter wraps to zero on the last step, ready for the next window.
        if (step) begin
            out_bit_d = cmp_bit;
            out_vld_d = 1'b1;
            win_cnt_d = win_cnt_q + WIN_ONE;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            win_cnt_q <= '0;
            out_bit_q <= 1'b0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state_q   <= state_d;
            data_q    <= data_d;
            win_cnt_q <= win_cnt_d;
            out_bit_q <= out_bit_d;
            out_vld_q <= out_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rng_en  = step;
    assign out_bit = out_bit_q;
    assign out_vld = out_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef SOBOL_STREAM_CTRL_ACC_EN
    logic [INWD:0] acc_q, acc_d;
    logic [INWD:0] result_q, result_d;

    always_comb begin
        acc_d    = acc_q;
        result_d = result_q;
        if (start_ok) acc_d = '0;
        // Result captures the count including the final bit, visible in DONE.
        if (step) begin
            acc_d = acc_q + {{INWD{1'b0}}, cmp_bit};
            if (last_step) result_d = acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
`else
    assign result = '0;
`endif

endmodule

// File: tb/tb_sobol_stream_ctrl.sv
// Self-checking bench for sobol_stream_ctrl with a behavioural 1-D Sobol RNG
// and a scoreboard queue of expected stream bits.
module tb_sobol_stream_ctrl;

    localparam int INWD = 4;
    localparam int WIN  = 16;
`ifdef SOBOL_STREAM_CTRL_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            hold = 1'b0;
    logic [INWD-1:0] src_data = '0;
    logic [INWD-1:0] rng_val;
    logic            rng_en, out_bit, out_vld, busy, done;
    logic [INWD:0]   result;

    always #5 clk = ~clk;

    sobol_stream_ctrl #(.INWD(INWD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_data (src_data),
        .hold     (hold),
        .rng_en   (rng_en),
        .rng_val  (rng_val),
        .out_bit  (out_bit),
        .out_vld  (out_vld),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Gray-code Sobol, first dimension: x(n+1) = x(n) ^ v[lowest zero bit of n].
    function automatic logic [INWD-1:0] sobol_dir(input logic [INWD-1:0] n);
        for (int k = 0; k < INWD; k++)
            if (!n[k]) return INWD'(8 >> k);
        return INWD'(1);
    endfunction

    logic [INWD-1:0] rng_idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rng_val <= '0;
            rng_idx <= '0;
        end else if (rng_en) begin
            rng_val <= rng_val ^ sobol_dir(rng_idx);
            rng_idx <= rng_idx + 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;
    int vld_cnt, ones_cnt, en_cnt, done_cnt;
    logic [INWD-1:0] exp_data = '0;
    bit exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: push the expected bit when the RNG is enabled, pop on out_vld.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_vld) begin
                vld_cnt++;
                ones_cnt += int'(out_bit);
                if (exp_q.size() == 0) check("sb_unexpected_vld", 1, 0);
                else check("sb_bit", int'(out_bit), int'(exp_q.pop_front()));
            end
            if (rng_en) begin
                en_cnt++;
                exp_q.push_back(exp_data > rng_val);
            end
            if (done) done_cnt++;
        end
    end

    task automatic kick(input logic [INWD-1:0] d, input logic h);
        start    = 1'b1;
        src_data = d;
        hold     = h;
        exp_data = d;
        vld_cnt  = 0;
        ones_cnt = 0;
        en_cnt   = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_window(input int hs, input int hl, input int pulse_at,
                               input int exp_ones, input int exp_run, input string tag);
        int run_cyc = -1;
        check({tag, "_busy_run"}, int'(busy), 1);
        for (int i = 0; i < 200; i++) begin
            hold  = (i >= hs) && (i < hs + hl);
            start = (i == pulse_at);
            if (i == pulse_at) src_data = 4'd12;
            @(negedge clk); #1;
            if (done) begin
                run_cyc = i;
                break;
            end
            @(posedge clk); #1;
        end
        hold  = 1'b0;
        start = 1'b0;
        check({tag, "_done_seen"}, int'(run_cyc >= 0), 1);
        check({tag, "_run_cycles"}, run_cyc, exp_run);
        check({tag, "_vld_count"}, vld_cnt, WIN);
        check({tag, "_rng_en_count"}, en_cnt, WIN);
        check({tag, "_ones"}, ones_cnt, exp_ones);
        check({tag, "_result"}, int'(result), ACC ? exp_ones : 0);
        check({tag, "_busy_done"}, int'(busy), 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic settle_idle(input int exp_ones, input string tag);
        @(posedge clk); #1;
        check({tag, "_idle_done"}, int'(done), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_rng_en"}, int'(rng_en), 0);
        check({tag, "_result_held"}, int'(result), ACC ? exp_ones : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_bit"}, int'(out_bit), 0);
        check({tag, "_out_vld"}, int'(out_vld), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_rng_en"}, int'(rng_en), 0);
    endtask

    typedef struct {
        logic [INWD-1:0] data;
        logic            hold_at_start;
        int              hs;
        int              hl;
        int              exp_ones;
        int              exp_run;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 4'd0,  hold_at_start: 1'b0, hs: 99, hl: 0, exp_ones: 0,  exp_run: 16};
        vecs[1] = '{data: 4'd15, hold_at_start: 1'b0, hs: 99, hl: 0, exp_ones: 15, exp_run: 16};
        vecs[2] = '{data: 4'd8,  hold_at_start: 1'b0, hs: 99, hl: 0, exp_ones: 8,  exp_run: 16};
        vecs[3] = '{data: 4'd5,  hold_at_start: 1'b0, hs: 6,  hl: 5, exp_ones: 5,  exp_run: 21};
        vecs[4] = '{data: 4'd1,  hold_at_start: 1'b1, hs: 0,  hl: 3, exp_ones: 1,  exp_run: 19};
        vecs[5] = '{data: 4'd14, hold_at_start: 1'b0, hs: 15, hl: 2, exp_ones: 14, exp_run: 18};

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            kick(vecs[v].data, vecs[v].hold_at_start);
            wait_window(vecs[v].hs, vecs[v].hl, -1, vecs[v].exp_ones, vecs[v].exp_run,
                        $sformatf("vec%0d", v));
            settle_idle(vecs[v].exp_ones, $sformatf("vec%0d", v));
        end

        // Start pulsed mid-window with new data must be ignored.
        kick(4'd3, 1'b0);
        wait_window(99, 0, 4, 3, 16, "busy_start");
        settle_idle(3, "busy_start");

        // Start held in the DONE cycle: second window follows with no IDLE gap.
        kick(4'd6, 1'b0);
        wait_window(99, 0, -1, 6, 16, "b2b_first");
        kick(4'd10, 1'b0);
        wait_window(99, 0, -1, 10, 16, "b2b_second");
        settle_idle(10, "b2b_second");

        // Reset at window cycle 7 aborts with no done pulse.
        kick(4'd9, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("mid_reset_no_done", done_cnt, 0);
        @(posedge clk); #1;
        kick(4'd11, 1'b0);
        wait_window(99, 0, -1, 11, 16, "after_reset");
        settle_idle(11, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
